// File: rtl/spu_reg_file_wb.sv
// spu_reg_file_wb: 3-read/2-write SPU register file with post-reset clear sweep.
// Define SPU_RF_BYPASS_EN for write-through reads (odd > even > array).
module spu_reg_file_wb #(
  parameter int NUM_REGS = 128,
  parameter int REG_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       ra_addr,
  input  logic [6:0]       rb_addr,
  input  logic [6:0]       rc_addr,
  output logic [REG_W-1:0] ra,
  output logic [REG_W-1:0] rb,
  output logic [REG_W-1:0] rc,
  input  logic [REG_W-1:0] rt_wb_e,
  input  logic [6:0]       rt_addr_wb_e,
  input  logic             reg_write_wb_e,
  input  logic [REG_W-1:0] rt_wb_o,
  input  logic [6:0]       rt_addr_wb_o,
  input  logic             reg_write_wb_o,
  output logic             busy,
  output logic             wr_conflict
);
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [6:0] clr_cnt;
  logic [REG_W-1:0] regs [NUM_REGS];
  logic [AW-1:0] ae, ao;
  logic we_e, we_o;
  assign ae = rt_addr_wb_e[AW-1:0];
  assign ao = rt_addr_wb_o[AW-1:0];
  assign we_e = state == READY && reg_write_wb_e;
  assign we_o = state == READY && reg_write_wb_o;
  assign busy = state == CLEAR;
  function automatic logic [REG_W-1:0] rd(input logic [6:0] a);
    logic [AW-1:0] i;
    i = a[AW-1:0];
    rd = regs[i];
`ifdef SPU_RF_BYPASS_EN
    if (we_e && ae == i) rd = rt_wb_e;
    if (we_o && ao == i) rd = rt_wb_o;
`endif
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      clr_cnt <= '0;
      ra <= '0;
      rb <= '0;
      rc <= '0;
      wr_conflict <= 1'b0;
    end else if (state == CLEAR) begin
      regs[clr_cnt[AW-1:0]] <= '0;
      clr_cnt <= clr_cnt + 7'd1;
      if (clr_cnt == 7'(NUM_REGS - 1)) state <= READY;
      ra <= '0;
      rb <= '0;
      rc <= '0;
      wr_conflict <= 1'b0;
    end else begin
      // odd write is issued last so it wins a same-address collision
      if (we_e) regs[ae] <= rt_wb_e;
      if (we_o) regs[ao] <= rt_wb_o;
      ra <= rd(ra_addr);
      rb <= rd(rb_addr);
      rc <= rd(rc_addr);
      wr_conflict <= we_e && we_o && ae == ao;
    end
  end
endmodule

// File: tb/tb_spu_reg_file_wb.sv
// tb_spu_reg_file_wb: directed stimulus with a cycle-tagged expectation queue drained by a monitor.
module tb_spu_reg_file_wb;
`ifdef SPU_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    int cyc;
    int sel;
    logic [127:0] v;
    string name;
  } exp_t;
  logic clk = 0, reset = 1;
  logic [6:0] ra_addr = 0, rb_addr = 0, rc_addr = 0, rt_addr_wb_e = 0, rt_addr_wb_o = 0;
  logic [127:0] ra, rb, rc, rt_wb_e = 0, rt_wb_o = 0;
  logic reg_write_wb_e = 0, reg_write_wb_o = 0, busy, wr_conflict;
  int cyc = 0, n_vec = 0, n_bad = 0;
  exp_t q[$];
  logic [127:0] d3, d5, d1, d2, d10, d11;
  spu_reg_file_wb dut (
    .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra(ra), .rb(rb), .rc(rc), .rt_wb_e(rt_wb_e), .rt_addr_wb_e(rt_addr_wb_e),
    .reg_write_wb_e(reg_write_wb_e), .rt_wb_o(rt_wb_o), .rt_addr_wb_o(rt_addr_wb_o),
    .reg_write_wb_o(reg_write_wb_o), .busy(busy), .wr_conflict(wr_conflict)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      logic [127:0] got;
      e = q.pop_front();
      got = e.sel == 0 ? ra : e.sel == 1 ? rb : e.sel == 2 ? rc :
            e.sel == 3 ? {127'd0, busy} : {127'd0, wr_conflict};
      n_vec++;
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got %h want %h", e.name, cyc, got, e.v);
      end
    end
  end
  task automatic ex(input int sel, input logic [127:0] v, input string name);
    q.push_back('{cyc + 1, sel, v, name});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input string tag);
    for (int i = 0; i < 128; i++) begin
      if (i == 127) begin
        reg_write_wb_e = 0;
        reg_write_wb_o = 0;
      end
      ex(3, {127'd0, i < 127}, {tag, "_busy"});
      ex(0, 0, {tag, "_ra"});
      ex(4, 0, {tag, "_wrc"});
      tick();
    end
  endtask
  initial begin
    d3 = {8{16'h0002}};
    d5 = {16'hFFFF, {6{16'h0002}}, 16'h0001};
    d1 = {32{4'h1}};
    d2 = {32{4'h2}};
    d10 = {4{32'hA0A0_0010}};
    d11 = {4{32'hB0B0_0011}};
    #1;
    for (int i = 0; i < 3; i++) begin
      ex(3, 1, "rst_busy");
      ex(0, 0, "rst_ra");
      ex(4, 0, "rst_wrc");
      tick();
    end
    reset = 0;
    ra_addr = 127;
    sweep("sweep1");
    reg_write_wb_e = 1; rt_addr_wb_e = 3; rt_wb_e = d3;
    ex(4, 0, "wr3_wrc");
    tick();
    reg_write_wb_e = 0; ra_addr = 3;
    ex(0, d3, "rd3");
    tick();
    reg_write_wb_o = 1; rt_addr_wb_o = 5; rt_wb_o = d5; rb_addr = 5;
    ex(1, BYP ? d5 : 128'd0, "same_edge_rb5");
    tick();
    reg_write_wb_o = 0;
    ex(1, d5, "rb5_after");
    tick();
    reg_write_wb_e = 1; rt_addr_wb_e = 9; rt_wb_e = d1;
    reg_write_wb_o = 1; rt_addr_wb_o = 9; rt_wb_o = d2; rc_addr = 9;
    ex(2, BYP ? d2 : 128'd0, "coll_byp_rc9");
    ex(4, 1, "coll_wrc");
    tick();
    reg_write_wb_e = 0; reg_write_wb_o = 0;
    ex(2, d2, "coll_rc9");
    ex(4, 0, "coll_wrc_pulse");
    tick();
    reg_write_wb_e = 1; rt_addr_wb_e = 10; rt_wb_e = d10;
    reg_write_wb_o = 1; rt_addr_wb_o = 11; rt_wb_o = d11;
    ra_addr = 10; rb_addr = 11; rc_addr = 3;
    ex(0, BYP ? d10 : 128'd0, "dual_byp_ra10");
    ex(1, BYP ? d11 : 128'd0, "dual_byp_rb11");
    ex(2, d3, "dual_rc3");
    ex(4, 0, "dual_wrc");
    tick();
    reg_write_wb_e = 0; reg_write_wb_o = 0;
    ex(0, d10, "dual_ra10");
    ex(1, d11, "dual_rb11");
    ex(4, 0, "dual_wrc_after");
    tick();
    reset = 1;
    ex(3, 1, "rst2_busy");
    ex(0, 0, "rst2_ra");
    tick();
    reset = 0;
    reg_write_wb_e = 1; rt_addr_wb_e = 0; rt_wb_e = '1;
    reg_write_wb_o = 1; rt_addr_wb_o = 0; rt_wb_o = '1;
    ra_addr = 0; rb_addr = 3; rc_addr = 9;
    for (int i = 0; i < 60; i++) begin
      ex(3, 1, "mid_busy");
      ex(0, 0, "mid_ra");
      ex(4, 0, "mid_wrc");
      tick();
    end
    reset = 1;
    ex(3, 1, "mid_rst_busy");
    tick();
    reset = 0;
    sweep("sweep2");
    reg_write_wb_o = 1; rt_addr_wb_o = 12; rt_wb_o = d11;
    ex(0, 0, "clr_ra0");
    ex(1, 0, "clr_rb3");
    ex(2, 0, "clr_rc9");
    ex(3, 0, "ready_busy");
    tick();
    reg_write_wb_o = 0; ra_addr = 12;
    ex(0, d11, "first_wr_ra12");
    tick();
    tick();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
